keypad_scanner: RTL and testbench

Input-side companion to the 4-digit seven-segment display driver. It scans a 4x4 active-low matrix keypad and debounces each complete scan frame. Each debounced key press becomes a one-cycle event carrying a 4-bit hex code. The last four pressed digits are kept in a 16-bit register that feeds the display's `number` input directly.

---
 rtl/keypad_scanner_pkg.sv | 52 +++++
 rtl/keypad_scanner_frame_debounce.sv | 73 +++++++
 rtl/keypad_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry,
// frame-result encoding and key-code helpers.
package keypad_scanner_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Classification of one complete scan frame
  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_SINGLE = 2'd1,
    KIND_MULTI  = 2'd2
  } frame_kind_e;

  // Frame result: code is meaningful only for KIND_SINGLE and is kept at
  // zero otherwise so whole-struct equality compares results correctly.
  typedef struct packed {
    frame_kind_e kind;
    logic [3:0]  code;
  } frame_result_t;

  localparam frame_result_t FRAME_NONE = '{kind: KIND_NONE, code: 4'd0};

  // Key code = 4*row + column, which is simply {row, column}
  function automatic logic [3:0] key_code_f(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    key_code_f = {row_idx, col_idx};
  endfunction

  // Number of pressed columns in one row sample (0..4)
  function automatic logic [2:0] press_count_f(input logic [COLS-1:0] pressed);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < COLS; i++) begin
      cnt = cnt + {2'b00, pressed[i]};
    end
    press_count_f = cnt;
  endfunction

  // Index of the lowest pressed column (0 when none is pressed)
  function automatic logic [1:0] first_col_f(input logic [COLS-1:0] pressed);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (pressed[i]) begin
        idx = 2'(i);
      end
    end
    first_col_f = idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_frame_debounce.sv
// Frame-level debouncer: a frame result becomes stable once it has been seen
// in DEBOUNCE consecutive frames. Reports the next stable value and a strobe
// in the cycle a stable change is committed.
module keypad_scanner_frame_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_done,
  input  frame_result_t frame_result,
  output logic          stable_change,
  output frame_result_t stable_result_next
);

  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  frame_result_t   prev_r;
  frame_result_t   stable_r;
  logic [MW-1:0]   match_r;

  frame_result_t   prev_next_s;
  frame_result_t   stable_next_s;
  logic [MW-1:0]   match_next_s;

  // Next-state: compare with previous frame, update saturating match count
  always_comb begin
    prev_next_s   = prev_r;
    stable_next_s = stable_r;
    match_next_s  = match_r;
    if (frame_done) begin
      prev_next_s = frame_result;
      if (frame_result == prev_r) begin
        if (match_r < MATCH_MAX) begin
          match_next_s = match_r + MATCH_ONE;
        end else begin
          match_next_s = match_r;
        end
      end else begin
        match_next_s = MATCH_ONE;
      end
      if (match_next_s == MATCH_MAX) begin
        stable_next_s = frame_result;
      end else begin
        stable_next_s = stable_r;
      end
    end else begin
      prev_next_s   = prev_r;
      stable_next_s = stable_r;
      match_next_s  = match_r;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r   <= FRAME_NONE;
      stable_r <= FRAME_NONE;
      match_r  <= '0;
    end else begin
      prev_r   <= prev_next_s;
      stable_r <= stable_next_s;
      match_r  <= match_next_s;
    end
  end

  assign stable_change      = (stable_next_s != stable_r);
  assign stable_result_next = stable_next_s;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner. Drives one row at a time, samples the
// synchronized columns at the end of each row period, classifies each frame,
// debounces frames and turns stable single-key results into key events plus
// a four-digit code history for the seven-segment display.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 50,
  parameter int DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic            key_held,
  output logic [15:0]     number
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [1:0]    ROW_LAST = 2'(ROWS - 1);

  logic [COLS-1:0] col_meta_r;
  logic [COLS-1:0] col_sync_r;
  logic [DW-1:0]   div_r;
  logic [1:0]      row_idx_r;
  logic [ROWS-1:0] row_r;
  logic [1:0]      acc_cnt_r;   // 0, 1, or 2 meaning "two or more"
  logic [3:0]      acc_code_r;
  logic            key_valid_r;
  logic [3:0]      key_code_r;
  logic            key_held_r;
  logic [15:0]     number_r;

  logic            sample_s;
  logic            frame_done_s;
  logic [1:0]      row_idx_next_s;
  logic [COLS-1:0] row_press_s;
  logic [2:0]      row_cnt_s;
  logic [3:0]      row_code_s;
  logic [2:0]      total_s;
  logic [1:0]      acc_cnt_next_s;
  logic [3:0]      acc_code_next_s;
  frame_result_t   frame_result_s;
  logic            stable_change_s;
  frame_result_t   stable_next_s;

  assign sample_s       = (div_r == DIV_LAST);
  assign frame_done_s   = sample_s && (row_idx_r == ROW_LAST);
  assign row_idx_next_s = row_idx_r + 2'd1;

  // Two-flop synchronizer for the asynchronous column inputs (idle = high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
    end
  end

  // Row-period divider and row drive; row output moves with the divider wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r     <= '0;
      row_idx_r <= 2'd0;
      row_r     <= 4'b1110;
    end else if (sample_s) begin
      div_r     <= '0;
      row_idx_r <= row_idx_next_s;
      row_r     <= ~(4'b0001 << row_idx_next_s);
    end else begin
      div_r     <= div_r + DIV_ONE;
      row_idx_r <= row_idx_r;
      row_r     <= row_r;
    end
  end

  // Merge the current row sample into the frame accumulator and classify
  always_comb begin
    row_press_s = ~col_sync_r;
    row_cnt_s   = press_count_f(row_press_s);
    row_code_s  = key_code_f(row_idx_r, first_col_f(row_press_s));
    total_s     = {1'b0, acc_cnt_r} + row_cnt_s;
    if (total_s >= 3'd2) begin
      acc_cnt_next_s = 2'd2;
    end else begin
      acc_cnt_next_s = total_s[1:0];
    end
    if (acc_cnt_r == 2'd0) begin
      acc_code_next_s = row_code_s;
    end else begin
      acc_code_next_s = acc_code_r;
    end
    frame_result_s = FRAME_NONE;
    case (acc_cnt_next_s)
      2'd0:    frame_result_s = FRAME_NONE;
      2'd1:    frame_result_s = '{kind: KIND_SINGLE, code: acc_code_next_s};
      default: frame_result_s = '{kind: KIND_MULTI, code: 4'd0};
    endcase
  end

  // Frame accumulator: gathers rows 0..2, cleared when row 3 closes the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (frame_done_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (sample_s) begin
      acc_cnt_r  <= acc_cnt_next_s;
      acc_code_r <= acc_code_next_s;
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      acc_code_r <= acc_code_r;
    end
  end

  keypad_scanner_frame_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk                (clk),
    .reset              (reset),
    .frame_done         (frame_done_s),
    .frame_result       (frame_result_s),
    .stable_change      (stable_change_s),
    .stable_result_next (stable_next_s)
  );

  // Key event outputs: act on stable-result changes only (no auto-repeat)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
      key_held_r  <= 1'b0;
      number_r    <= 16'h0000;
    end else begin
      key_valid_r <= 1'b0;
      if (stable_change_s) begin
        case (stable_next_s.kind)
          KIND_SINGLE: begin
            key_valid_r <= 1'b1;
            key_code_r  <= stable_next_s.code;
            key_held_r  <= 1'b1;
            number_r    <= {number_r[11:0], stable_next_s.code};
          end
          KIND_NONE: begin
            key_held_r <= 1'b0;
          end
          KIND_MULTI: begin
            key_held_r <= key_held_r;
          end
          default: begin
            key_held_r <= key_held_r;
          end
        endcase
      end else begin
        key_held_r <= key_held_r;
      end
    end
  end

  assign row       = row_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign key_held  = key_held_r;
  assign number    = number_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2).
// A frame is 16 cycles; keys change only at frame starts, counted in
// falling edges from reset release.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] number;

  logic [15:0] keys;
  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  int          doubles = 0;
  int          cyc = 0;
  logic        prev_valid = 1'b0;

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .number    (number)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (key_valid) begin
        pulses++;
        if (prev_valid) doubles++;
      end
      prev_valid = key_valid;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    reset = 1'b0;
    keys  = 16'h0000;
    step(3);
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b want 1110", row); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code: got %h want 0", key_code); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b want 0", key_held); end
    checks++; if (number !== 16'h0000) begin failures++; $display("FAIL reset_number: got %h want 0000", number); end
    reset = 1'b1;
    cyc = 0;
    pulses = 0;
    for (int i = 1; i < 48; i++) begin
      step(1);
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      checks++; if (row !== exp_row) begin failures++; $display("FAIL scan_row cyc=%0d: got %b want %b", i, row, exp_row); end
    end
    step(1);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    checks++; if (number !== 16'h0000) begin failures++; $display("FAIL idle_number: got %h want 0000", number); end
  endtask

  task automatic test_single_press();
    int p0;
    p0 = pulses;
    keys[9] = 1'b1;
    step(31);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL single_early: got %b want 0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", key_valid); end
    checks++; if (key_code !== 4'h9) begin failures++; $display("FAIL single_code: got %h want 9", key_code); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL single_held: got %b want 1", key_held); end
    checks++; if (number !== 16'h0009) begin failures++; $display("FAIL single_number: got %h want 0009", number); end
    step(1);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL single_width: got %b want 0", key_valid); end
    step(15);
    keys = 16'h0000;
    step(31);
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL release_held_early: got %b want 1", key_held); end
    step(1);
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL release_held: got %b want 0", key_held); end
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    checks++; if (key_code !== 4'h9) begin failures++; $display("FAIL release_code: got %h want 9", key_code); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulses;
    for (int f = 0; f < 4; f++) begin
      keys[5] = ((f % 2) == 0);
      step(16);
    end
    keys[5] = 1'b1;
    step(31);
    checks++; if (pulses !== p0) begin failures++; $display("FAIL bounce_early: got %0d pulses want 0", pulses - p0); end
    step(1);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bounce_valid: got %b want 1", key_valid); end
    checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL bounce_code: got %h want 5", key_code); end
    checks++; if (number !== 16'h0095) begin failures++; $display("FAIL bounce_number: got %h want 0095", number); end
    step(16);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL bounce_repeat: got %0d want 1", pulses - p0); end
    keys = 16'h0000;
    step(32);
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_release: got %b want 0", key_held); end
  endtask

  task automatic test_multi_rollover();
    int p0;
    p0 = pulses;
    keys[3] = 1'b1;
    step(32);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'h3) begin failures++; $display("FAIL key3_event: got valid=%b code=%h want 1/3", key_valid, key_code); end
    checks++; if (number !== 16'h0953) begin failures++; $display("FAIL key3_number: got %h want 0953", number); end
    keys[7] = 1'b1;
    step(32);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL multi_pulses: got %0d want 1", pulses - p0); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL multi_held: got %b want 1", key_held); end
    checks++; if (key_code !== 4'h3) begin failures++; $display("FAIL multi_code: got %h want 3", key_code); end
    checks++; if (number !== 16'h0953) begin failures++; $display("FAIL multi_number: got %h want 0953", number); end
    keys[3] = 1'b0;
    step(31);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL rollover_early: got %0d want 1", pulses - p0); end
    step(1);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'h7) begin failures++; $display("FAIL rollover_event: got valid=%b code=%h want 1/7", key_valid, key_code); end
    checks++; if (number !== 16'h9537) begin failures++; $display("FAIL rollover_number: got %h want 9537", number); end
    keys = 16'h0000;
    step(32);
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rollover_release: got %b want 0", key_held); end
  endtask

  task automatic test_history();
    int p0;
    p0 = pulses;
    for (int k = 1; k <= 5; k++) begin
      keys = 16'h0000;
      keys[k] = 1'b1;
      step(32);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(k)) begin failures++; $display("FAIL history_event k=%0d: got valid=%b code=%h", k, key_valid, key_code); end
      keys = 16'h0000;
      step(32);
    end
    checks++; if (pulses - p0 !== 5) begin failures++; $display("FAIL history_pulses: got %0d want 5", pulses - p0); end
    checks++; if (number !== 16'h2345) begin failures++; $display("FAIL history_number: got %h want 2345", number); end
    checks++; if (doubles !== 0) begin failures++; $display("FAIL pulse_width: got %0d long pulses want 0", doubles); end
  endtask

  task automatic test_mid_frame_reset();
    keys = 16'h0000;
    keys[10] = 1'b1;
    step(21);
    #2 reset = 1'b0;
    #1;
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL midreset_row: got %b want 1110", row); end
    checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin failures++; $display("FAIL midreset_flags: got valid=%b held=%b want 0/0", key_valid, key_held); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL midreset_code: got %h want 0", key_code); end
    checks++; if (number !== 16'h0000) begin failures++; $display("FAIL midreset_number: got %h want 0000", number); end
    step(2);
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL inreset_row: got %b want 1110", row); end
    reset = 1'b1;
    cyc = 0;
    step(31);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL postreset_early: got %b want 0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'hA) begin failures++; $display("FAIL postreset_event: got valid=%b code=%h want 1/A", key_valid, key_code); end
    checks++; if (number !== 16'h000A) begin failures++; $display("FAIL postreset_number: got %h want 000A", number); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL postreset_held: got %b want 1", key_held); end
    step(1);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL postreset_width: got %b want 0", key_valid); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_rollover();
    test_history();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
